// File: rtl/lcd_pkg.sv
// Shared image constants and capture-state encoding for the LCD result path.
package lcd_pkg;

    localparam int IMG_W     = 8;
    localparam int IMG_DEPTH = IMG_W * IMG_W;
    localparam int PIX_W     = 8;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DUMP    = 2'd1,
        FINISH  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/irb_capture_buffer_next_written.sv
// irb_next_written: finds the lowest set bit of mask at an index >= start.
// Combinational only; found=0 when no such bit exists (start may equal 2**AW).
module irb_next_written #(
    parameter int AW = 6
) (
    input  logic [2**AW-1:0] mask,
    input  logic [AW:0]      start,
    output logic             found,
    output logic [AW-1:0]    idx
);

    localparam int DEPTH = 2 ** AW;

    logic [DEPTH-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && ((AW+1)'(gi) >= start);
        end
    endgenerate

    // Descending scan so the lowest candidate is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                idx   = AW'(i);
            end
        end
    end

endmodule

// File: rtl/irb_capture_buffer.sv
// Captures the controller's IRB writes into a 64-pixel image, then streams it out with a checksum.
// Optional macro DUMP_SKIP_EMPTY_EN: stream only addresses that were actually written.
module irb_capture_buffer
    import lcd_pkg::*;
#(
    parameter int DW  = PIX_W,
    parameter int AW  = 6,
    parameter int CSW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           IRB_RW,
    input  logic [AW-1:0]  IRB_A,
    input  logic [DW-1:0]  IRB_D,
    input  logic           done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_addr,
    output logic [DW-1:0]  out_data,
    output logic           out_last,
    output logic [CSW-1:0] checksum,
    output logic           checksum_valid,
    output logic [AW:0]    wr_count,
    output logic           err_late
);

    localparam int DEPTH = 2 ** AW;

    cap_state_e       state_q, state_d;
    logic [DEPTH-1:0] written_q, written_d, written_upd;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_count_q, wr_count_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic [CSW-1:0]   checksum_q, checksum_d;
    logic             err_late_q, err_late_d;

    logic             wr_en, beat_xfer, at_last, dump_empty;
    logic [AW-1:0]    first_addr, next_addr;

    assign wr_en       = (state_q == CAPTURE) && !IRB_RW;
    assign written_upd = wr_en ? (written_q | (DEPTH'(1) << IRB_A)) : written_q;
    assign beat_xfer   = out_valid && out_ready;

    assign out_valid      = (state_q == DUMP);
    assign out_last       = out_valid && at_last;
    assign out_addr       = out_addr_q;
    // Unwritten entries hold stale data from before reset; mask them to zero.
    assign out_data       = written_q[out_addr_q] ? mem_q[out_addr_q] : '0;
    assign checksum       = checksum_q;
    assign checksum_valid = (state_q == FINISH);
    assign wr_count       = wr_count_q;
    assign err_late       = err_late_q;

`ifdef DUMP_SKIP_EMPTY_EN
    logic [DEPTH-1:0] search_mask;
    logic [AW:0]      search_start;
    logic             search_found;
    logic [AW-1:0]    search_idx;

    // In CAPTURE the search looks for the first written address (including a write
    // landing with done); in DUMP it looks for the next one above the current beat.
    assign search_mask  = (state_q == CAPTURE) ? written_upd : written_q;
    assign search_start = (state_q == CAPTURE) ? '0 : ({1'b0, out_addr_q} + (AW+1)'(1));

    irb_next_written #(
        .AW(AW)
    ) u_next_written (
        .mask (search_mask),
        .start(search_start),
        .found(search_found),
        .idx  (search_idx)
    );

    assign first_addr = search_idx;
    assign next_addr  = search_idx;
    assign dump_empty = !search_found;
    assign at_last    = !search_found;
`else
    assign first_addr = '0;
    assign next_addr  = out_addr_q + AW'(1);
    assign dump_empty = 1'b0;
    assign at_last    = (out_addr_q == AW'(DEPTH - 1));
`endif

    always_comb begin
        state_d    = state_q;
        written_d  = written_upd;
        wr_count_d = wr_count_q;
        out_addr_d = out_addr_q;
        checksum_d = checksum_q;
        err_late_d = err_late_q;

        if (wr_en && !written_q[IRB_A]) begin
            wr_count_d = wr_count_q + (AW+1)'(1);
        end
        if (!IRB_RW && (state_q != CAPTURE)) begin
            err_late_d = 1'b1;
        end

        case (state_q)
            CAPTURE: begin
                if (done) begin
                    state_d    = dump_empty ? FINISH : DUMP;
                    out_addr_d = first_addr;
                end
            end
            DUMP: begin
                if (beat_xfer) begin
                    checksum_d = checksum_q + CSW'(out_data);
                    if (at_last) begin
                        state_d = FINISH;
                    end else begin
                        out_addr_d = next_addr;
                    end
                end
            end
            FINISH: begin
                state_d = FINISH;
            end
            default: begin
                state_d = CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= CAPTURE;
            written_q  <= '0;
            wr_count_q <= '0;
            out_addr_q <= '0;
            checksum_q <= '0;
            err_late_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            written_q  <= written_d;
            wr_count_q <= wr_count_d;
            out_addr_q <= out_addr_d;
            checksum_q <= checksum_d;
            err_late_q <= err_late_d;
        end
    end

    // Storage carries no reset; the written mask qualifies every read.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[IRB_A] <= IRB_D;
        end
    end

endmodule

// File: tb/tb_irb_capture_buffer.sv
// Scoreboard bench for irb_capture_buffer (default build): expected beats are queued by the
// stimulus and popped by a negedge monitor as the DUT transfers them.
module tb_irb_capture_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        IRB_RW;
    logic [5:0]  IRB_A;
    logic [7:0]  IRB_D;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_addr;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] checksum;
    logic        checksum_valid;
    logic [6:0]  wr_count;
    logic        err_late;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] img_m [64];
    logic       wr_m  [64];
    int         n_vec = 0;
    int         n_bad = 0;
    int         valid_cycles = 0;
    int         popped = 0;

    always #5 clk = ~clk;

    irb_capture_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .IRB_RW        (IRB_RW),
        .IRB_A         (IRB_A),
        .IRB_D         (IRB_D),
        .done          (done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .out_last      (out_last),
        .checksum      (checksum),
        .checksum_valid(checksum_valid),
        .wr_count      (wr_count),
        .err_late      (err_late)
    );

    // Monitor: every valid beat is compared with the queue head; popped only on transfer.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            valid_cycles++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got addr=%0d data=%02h, required no beat", out_addr, out_data);
            end else begin
                if ({out_addr, out_data, out_last} !== {exp_q[0].addr, exp_q[0].data, exp_q[0].last}) begin
                    n_bad++;
                    $display("FAIL beat: got addr=%0d data=%02h last=%0b, required addr=%0d data=%02h last=%0b",
                             out_addr, out_data, out_last, exp_q[0].addr, exp_q[0].data, exp_q[0].last);
                end
                if (out_ready) begin
                    $display("beat addr=%0d data=%02h last=%0b", out_addr, out_data, out_last);
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        IRB_RW    = 1'b1;
        IRB_A     = '0;
        IRB_D     = '0;
        done      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            img_m[i] = 8'h00;
            wr_m[i]  = 1'b0;
        end
        reset        = 1'b1;
        valid_cycles = 0;
        popped       = 0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d, input bit stored);
        IRB_RW = 1'b0;
        IRB_A  = a;
        IRB_D  = d;
        if (stored) begin
            img_m[a] = d;
            wr_m[a]  = 1'b1;
        end
        tick();
        IRB_RW = 1'b1;
    endtask

    task automatic push_expected();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back('{addr: 6'(i), data: (wr_m[i] ? img_m[i] : 8'h00), last: (i == 63)});
        end
    endtask

    task automatic wait_finish(input int budget);
        int n = 0;
        while (checksum_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (checksum_valid !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL finish_timeout: got checksum_valid=%0b after %0d cycles, required 1", checksum_valid, budget);
        end
    endtask

    initial begin
        apply_reset();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_checksum", 32'(checksum), 0);
        check("rst_checksum_valid", 32'(checksum_valid), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_err_late", 32'(err_late), 0);

        // Ramp image, ready held high: 64 beats back to back
        for (int i = 0; i < 64; i++) do_write(6'(i), 8'(i), 1'b1);
        push_expected();
        out_ready = 1'b1;
        done      = 1'b1;
        tick();
        wait_finish(200);
        check("ramp_checksum", 32'(checksum), 32'h07E0);
        check("ramp_checksum_valid", 32'(checksum_valid), 1);
        check("ramp_wr_count", 32'(wr_count), 64);
        check("ramp_valid_cycles", 32'(valid_cycles), 64);
        check("ramp_queue_left", 32'(exp_q.size()), 0);
        check("ramp_err_late", 32'(err_late), 0);
        check("finish_out_valid", 32'(out_valid), 0);

        // Rewrite of one address: last write wins, count stays 1
        apply_reset();
        do_write(6'd5, 8'h11, 1'b1);
        do_write(6'd5, 8'hAA, 1'b1);
        check("rewrite_wr_count", 32'(wr_count), 1);
        push_expected();
        out_ready = 1'b1;
        done      = 1'b1;
        tick();
        wait_finish(200);
        check("rewrite_checksum", 32'(checksum), 32'h00AA);
        check("rewrite_queue_left", 32'(exp_q.size()), 0);

        // All 0xFF with ready toggling 1,0,1,0...
        apply_reset();
        for (int i = 0; i < 64; i++) do_write(6'(i), 8'hFF, 1'b1);
        push_expected();
        done = 1'b1;
        tick();
        valid_cycles = 0;
        for (int k = 0; k < 127; k++) begin
            out_ready = (k % 2 == 0);
            tick();
        end
        check("stall_checksum_valid", 32'(checksum_valid), 1);
        check("stall_checksum", 32'(checksum), 32'h3FC0);
        check("stall_valid_cycles", 32'(valid_cycles), 127);
        check("stall_wr_count", 32'(wr_count), 64);
        check("stall_queue_left", 32'(exp_q.size()), 0);

        // Write together with done is kept; write during DUMP is dropped and flagged
        apply_reset();
        out_ready = 1'b1;
        IRB_RW    = 1'b0;
        IRB_A     = 6'd63;
        IRB_D     = 8'h7E;
        img_m[63] = 8'h7E;
        wr_m[63]  = 1'b1;
        push_expected();
        done = 1'b1;
        tick();
        IRB_RW = 1'b1;
        check("late_err_before", 32'(err_late), 0);
        do_write(6'd3, 8'h55, 1'b0);
        check("late_err_after", 32'(err_late), 1);
        wait_finish(200);
        check("late_checksum", 32'(checksum), 32'h007E);
        check("late_wr_count", 32'(wr_count), 1);
        check("late_err_sticky", 32'(err_late), 1);
        check("late_queue_left", 32'(exp_q.size()), 0);

        // Reset after 10 beats aborts the dump; then a fresh capture dumps from 0
        apply_reset();
        for (int i = 0; i < 64; i++) do_write(6'(i), 8'(i), 1'b1);
        push_expected();
        out_ready = 1'b1;
        done      = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) tick();
        check("abort_popped", 32'(popped), 10);
        reset = 1'b0;
        done  = 1'b0;
        tick();
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_checksum", 32'(checksum), 0);
        check("abort_wr_count", 32'(wr_count), 0);
        check("abort_out_addr", 32'(out_addr), 0);
        check("abort_err_late", 32'(err_late), 0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            img_m[i] = 8'h00;
            wr_m[i]  = 1'b0;
        end
        reset = 1'b1;
        do_write(6'd0, 8'h3C, 1'b1);
        do_write(6'd1, 8'h01, 1'b1);
        push_expected();
        done = 1'b1;
        tick();
        check("fresh_first_addr", 32'(out_addr), 0);
        wait_finish(200);
        check("fresh_checksum", 32'(checksum), 32'h003D);
        check("fresh_wr_count", 32'(wr_count), 2);
        check("fresh_queue_left", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
